// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths and constants for the operand fetch stage and its scoreboard.
package operand_fetch_stage_pkg;

    localparam int RF_ADDR_LEN = 5;
    localparam int RF_DATA_LEN = 32;
    localparam int CTRL_LEN    = 16;

    // x0 reads as zero and can never be a pending destination.
    localparam logic [RF_ADDR_LEN-1:0] REG_ZERO = '0;

endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// Pending-destination scoreboard: one bit per register, set on issue, cleared by
// writeback or by killing the instruction held in the output slot.
module operand_fetch_stage_reg_scoreboard
    import operand_fetch_stage_pkg::*;
#(
    parameter int ADDR_LEN = RF_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_en,
    input  logic [ADDR_LEN-1:0] clr_addr,
    input  logic                kill_en,
    input  logic [ADDR_LEN-1:0] kill_addr,
    input  logic                set_en,
    input  logic [ADDR_LEN-1:0] set_addr,
    input  logic [ADDR_LEN-1:0] rs1_addr,
    input  logic [ADDR_LEN-1:0] rs2_addr,
    input  logic                uses_rs1,
    input  logic                uses_rs2,
    input  logic [ADDR_LEN-1:0] rd_addr,
    input  logic                rd_we,
    output logic                raw_hazard,
    output logic                waw_hazard
);

    localparam int NUM_REGS = 1 << ADDR_LEN;
    localparam logic [ADDR_LEN-1:0] ZERO_ADDR = ADDR_LEN'(REG_ZERO);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                raw_rs1;
    logic                raw_rs2;

    // Set is applied last so a same-cycle clear of the same index loses.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (kill_en) begin
            pending_d[kill_addr] = 1'b0;
        end
        if (set_en && (set_addr != ZERO_ADDR)) begin
            pending_d[set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A writeback landing this cycle resolves the hazard through forwarding.
    always_comb begin
        raw_rs1    = uses_rs1 && pending_q[rs1_addr] && !(clr_en && (clr_addr == rs1_addr));
        raw_rs2    = uses_rs2 && pending_q[rs2_addr] && !(clr_en && (clr_addr == rs2_addr));
        raw_hazard = raw_rs1 || raw_rs2;
        waw_hazard = rd_we && (rd_addr != ZERO_ADDR) && pending_q[rd_addr]
                     && !(clr_en && (clr_addr == rd_addr));
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives register file reads, forwards writeback data,
// stalls on RAW/WAW hazards and registers operands into a valid/ready slot.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int RF_ADDR_LEN = operand_fetch_stage_pkg::RF_ADDR_LEN,
    parameter int RF_DATA_LEN = operand_fetch_stage_pkg::RF_DATA_LEN,
    parameter int CTRL_LEN    = operand_fetch_stage_pkg::CTRL_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RF_ADDR_LEN-1:0] in_rs1_addr,
    input  logic [RF_ADDR_LEN-1:0] in_rs2_addr,
    input  logic                   in_uses_rs1,
    input  logic                   in_uses_rs2,
    input  logic [RF_ADDR_LEN-1:0] in_rd_addr,
    input  logic                   in_rd_we,
    input  logic [RF_DATA_LEN-1:0] in_imm,
    input  logic [CTRL_LEN-1:0]    in_ctrl,
    output logic [RF_ADDR_LEN-1:0] rf_rs1_addr,
    output logic [RF_ADDR_LEN-1:0] rf_rs2_addr,
    input  logic [RF_DATA_LEN-1:0] rf_rs1_data,
    input  logic [RF_DATA_LEN-1:0] rf_rs2_data,
    input  logic                   wb_w_en,
    input  logic [RF_ADDR_LEN-1:0] wb_rd_addr,
    input  logic [RF_DATA_LEN-1:0] wb_data,
    input  logic                   kill,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RF_DATA_LEN-1:0] out_rs1_data,
    output logic [RF_DATA_LEN-1:0] out_rs2_data,
    output logic [RF_DATA_LEN-1:0] out_imm,
    output logic [RF_ADDR_LEN-1:0] out_rd_addr,
    output logic                   out_rd_we,
    output logic [CTRL_LEN-1:0]    out_ctrl
);

    logic                   raw_hazard;
    logic                   waw_hazard;
    logic                   stall;
    logic                   issue;
    logic [RF_DATA_LEN-1:0] op1;
    logic [RF_DATA_LEN-1:0] op2;

    logic                   out_valid_q,    out_valid_d;
    logic [RF_DATA_LEN-1:0] out_rs1_data_q, out_rs1_data_d;
    logic [RF_DATA_LEN-1:0] out_rs2_data_q, out_rs2_data_d;
    logic [RF_DATA_LEN-1:0] out_imm_q,      out_imm_d;
    logic [RF_ADDR_LEN-1:0] out_rd_addr_q,  out_rd_addr_d;
    logic                   out_rd_we_q,    out_rd_we_d;
    logic [CTRL_LEN-1:0]    out_ctrl_q,     out_ctrl_d;

    assign rf_rs1_addr = in_rs1_addr;
    assign rf_rs2_addr = in_rs2_addr;

    operand_fetch_stage_reg_scoreboard #(
        .ADDR_LEN (RF_ADDR_LEN)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .clr_en     (wb_w_en),
        .clr_addr   (wb_rd_addr),
        .kill_en    (kill && out_valid_q && out_rd_we_q),
        .kill_addr  (out_rd_addr_q),
        .set_en     (issue && in_rd_we),
        .set_addr   (in_rd_addr),
        .rs1_addr   (in_rs1_addr),
        .rs2_addr   (in_rs2_addr),
        .uses_rs1   (in_uses_rs1),
        .uses_rs2   (in_uses_rs2),
        .rd_addr    (in_rd_addr),
        .rd_we      (in_rd_we),
        .raw_hazard (raw_hazard),
        .waw_hazard (waw_hazard)
    );

    // The register file only commits the writeback at the clock edge, so bypass it here.
    always_comb begin
        op1 = rf_rs1_data;
        op2 = rf_rs2_data;
        if (wb_w_en && (wb_rd_addr == in_rs1_addr) && (in_rs1_addr != '0)) begin
            op1 = wb_data;
        end
        if (wb_w_en && (wb_rd_addr == in_rs2_addr) && (in_rs2_addr != '0)) begin
            op2 = wb_data;
        end
    end

    always_comb begin
        stall    = raw_hazard || waw_hazard;
        in_ready = !stall && (!out_valid_q || out_ready || kill);
        issue    = in_valid && in_ready;
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_rs1_data_d = out_rs1_data_q;
        out_rs2_data_d = out_rs2_data_q;
        out_imm_d      = out_imm_q;
        out_rd_addr_d  = out_rd_addr_q;
        out_rd_we_d    = out_rd_we_q;
        out_ctrl_d     = out_ctrl_q;
        if (issue) begin
            out_valid_d    = 1'b1;
            out_rs1_data_d = op1;
            out_rs2_data_d = op2;
            out_imm_d      = in_imm;
            out_rd_addr_d  = in_rd_addr;
            out_rd_we_d    = in_rd_we;
            out_ctrl_d     = in_ctrl;
        end else if (out_ready || kill) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q    <= 1'b0;
            out_rs1_data_q <= '0;
            out_rs2_data_q <= '0;
            out_imm_q      <= '0;
            out_rd_addr_q  <= '0;
            out_rd_we_q    <= 1'b0;
            out_ctrl_q     <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_rs1_data_q <= out_rs1_data_d;
            out_rs2_data_q <= out_rs2_data_d;
            out_imm_q      <= out_imm_d;
            out_rd_addr_q  <= out_rd_addr_d;
            out_rd_we_q    <= out_rd_we_d;
            out_ctrl_q     <= out_ctrl_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1_data = out_rs1_data_q;
    assign out_rs2_data = out_rs2_data_q;
    assign out_imm      = out_imm_q;
    assign out_rd_addr  = out_rd_addr_q;
    assign out_rd_we    = out_rd_we_q;
    assign out_ctrl     = out_ctrl_q;

endmodule
